// File: rtl/pixel_write_arbiter_pkg.sv
// Shared constants for the Mandelbrot pixel write path: pixel width,
// default bus widths and the escape-count color bands (RRRGGGBB).
package pixel_write_arbiter_pkg;

  localparam int unsigned PIX_W           = 8;
  localparam int unsigned DEFAULT_ADDR_W  = 19;
  localparam int unsigned DEFAULT_COUNT_W = 11;

  localparam int unsigned THRESH_BAND_64 = 64;
  localparam int unsigned THRESH_BAND_32 = 32;
  localparam int unsigned THRESH_BAND_16 = 16;
  localparam int unsigned THRESH_BAND_8  = 8;
  localparam int unsigned THRESH_BAND_4  = 4;

  localparam logic [PIX_W-1:0] COLOR_IN_SET  = 8'h00;
  localparam logic [PIX_W-1:0] COLOR_BAND_64 = 8'hE0;
  localparam logic [PIX_W-1:0] COLOR_BAND_32 = 8'hFC;
  localparam logic [PIX_W-1:0] COLOR_BAND_16 = 8'h1C;
  localparam logic [PIX_W-1:0] COLOR_BAND_8  = 8'h1F;
  localparam logic [PIX_W-1:0] COLOR_BAND_4  = 8'h03;
  localparam logic [PIX_W-1:0] COLOR_BAND_0  = 8'h92;

endpackage

// File: rtl/pixel_write_arbiter_iter_color_map.sv
// Escape-iteration count to 8-bit 3-3-2 color; purely combinational.
module iter_color_map
  import pixel_write_arbiter_pkg::*;
#(
  parameter int unsigned COUNT_W        = DEFAULT_COUNT_W,
  parameter int unsigned MAX_ITERATIONS = 100
) (
  input  logic [COUNT_W-1:0] count,
  output logic [PIX_W-1:0]   color_c
);

  logic [31:0] count_ext;

  // Highest band wins; counts at or above the limit are inside the set.
  always_comb begin
    count_ext = 32'(count);
    color_c   = COLOR_BAND_0;
    if (count_ext >= 32'(MAX_ITERATIONS))      color_c = COLOR_IN_SET;
    else if (count_ext >= 32'(THRESH_BAND_64)) color_c = COLOR_BAND_64;
    else if (count_ext >= 32'(THRESH_BAND_32)) color_c = COLOR_BAND_32;
    else if (count_ext >= 32'(THRESH_BAND_16)) color_c = COLOR_BAND_16;
    else if (count_ext >= 32'(THRESH_BAND_8))  color_c = COLOR_BAND_8;
    else if (count_ext >= 32'(THRESH_BAND_4))  color_c = COLOR_BAND_4;
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing one pixel-memory write port among iterator
// lanes, with a registered write stage, write counter and frame-done flag.
module pixel_write_arbiter
  import pixel_write_arbiter_pkg::*;
#(
  parameter int unsigned PARTITION      = 2,
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned COUNT_W        = DEFAULT_COUNT_W,
  parameter int unsigned MAX_ITERATIONS = 100,
  parameter int unsigned TOTAL_PIXELS   = 307200
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PARTITION-1:0]           req_valid,
  input  logic [PARTITION*ADDR_W-1:0]    req_addr,
  input  logic [PARTITION*COUNT_W-1:0]   req_count,
  output logic [PARTITION-1:0]           req_ready,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [PIX_W-1:0]               mem_data,
  input  logic                           mem_ready,
  output logic [31:0]                    pixel_cnt,
  output logic                           frame_done
);

  localparam int unsigned PTR_W = (PARTITION > 1) ? $clog2(PARTITION) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx_c;
  logic [PTR_W-1:0]   next_ptr_c;
  logic               grant_found_c;
  logic               stage_open_c;
  logic               accept_c;
  logic               final_accept_c;
  logic               grant_en_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [COUNT_W-1:0] sel_count_c;
  logic [PIX_W-1:0]   sel_color_c;
  int unsigned        idx_c;

  assign stage_open_c   = ~mem_write | mem_ready;
  assign accept_c       = mem_write & mem_ready;
  // The write that completes the frame blocks the reload, so the count stops at TOTAL_PIXELS.
  assign final_accept_c = accept_c & (pixel_cnt == 32'(TOTAL_PIXELS - 1));
  assign grant_en_c     = ~reset & stage_open_c & ~frame_done & ~final_accept_c & grant_found_c;

  // First valid lane at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    idx_c         = 0;
    for (int unsigned k = 0; k < PARTITION; k++) begin
      idx_c = (32'(rr_ptr) + k) % PARTITION;
      if (!grant_found_c && req_valid[PTR_W'(idx_c)]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = PTR_W'(idx_c);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_en_c) req_ready[grant_idx_c] = 1'b1;
  end

  assign next_ptr_c  = (grant_idx_c == PTR_W'(PARTITION - 1)) ? '0 : grant_idx_c + 1'b1;
  assign sel_addr_c  = req_addr[32'(grant_idx_c) * ADDR_W +: ADDR_W];
  assign sel_count_c = req_count[32'(grant_idx_c) * COUNT_W +: COUNT_W];

  iter_color_map #(
    .COUNT_W        (COUNT_W),
    .MAX_ITERATIONS (MAX_ITERATIONS)
  ) u_color_map (
    .count   (sel_count_c),
    .color_c (sel_color_c)
  );

  // Write stage: reload on transfer, empty when drained, hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      pixel_cnt  <= '0;
      frame_done <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      if (accept_c) begin
        pixel_cnt <= pixel_cnt + 32'd1;
        if (final_accept_c) frame_done <= 1'b1;
      end
      if (grant_en_c) begin
        mem_write <= 1'b1;
        mem_addr  <= sel_addr_c;
        mem_data  <= sel_color_c;
        rr_ptr    <= next_ptr_c;
      end else if (stage_open_c) begin
        mem_write <= 1'b0;
      end
    end
  end

endmodule
